// File: rtl/servo_sweep_ctrl_if.sv
// ---------------------------------------------------------------------------
// servo_sweep_ctrl_if
// Command handshake bundle between the top-level FSM (master) and the servo
// sweep controller (slave).
//   cmd_valid  master->slave  command offered
//   cmd_ready  slave->master  command slot free (no command pending)
//   cmd_op     master->slave  00 STOP, 01 START, 10 HOME, 11 reserved
//   speed      master->slave  dwell length in units of DWELL_UNIT frames
// ---------------------------------------------------------------------------
interface servo_sweep_ctrl_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [2:0] speed;

    modport master (output cmd_valid, output cmd_op, output speed, input cmd_ready);
    modport slave  (input cmd_valid, input cmd_op, input speed, output cmd_ready);
endinterface

// File: rtl/servo_sweep_ctrl.sv
// ---------------------------------------------------------------------------
// servo_sweep_ctrl
// Sequences a hobby-servo PWM channel: sweeps the pulse width between POS_MIN
// and POS_MAX in STEP increments (one step per frame), dwelling at each end
// for speed*DWELL_UNIT frames. Commands arrive over a valid/ready handshake,
// are held pending and applied at the next frame boundary.
// Ports:
//   clk      system clock
//   rst_n    asynchronous reset, active low
//   cmd      command handshake (servo_sweep_ctrl_if.slave)
//   pwm_out  servo pulse, high while frame tick count < pos
//   pos      pulse width applied in the current frame (ticks)
//   busy     1 in every state except IDLE
//   end_irq  one-clk pulse when pos arrives at POS_MAX or POS_MIN
//            (present only with SERVO_ENDPOINT_IRQ_EN defined)
// Optional feature macro: SERVO_ENDPOINT_IRQ_EN
// ---------------------------------------------------------------------------
module servo_sweep_ctrl #(
    parameter int TICK_DIV    = 500,
    parameter int FRAME_TICKS = 2000,
    parameter int POS_MIN     = 100,
    parameter int POS_MAX     = 200,
    parameter int STEP        = 2,
    parameter int DWELL_UNIT  = 25
) (
    input  logic                     clk,
    input  logic                     rst_n,
    servo_sweep_ctrl_if.slave        cmd,
    output logic                     pwm_out,
    output logic [7:0]               pos,
    output logic                     busy
`ifdef SERVO_ENDPOINT_IRQ_EN
    ,
    output logic                     end_irq
`endif
);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_UP       = 3'd1,
        ST_DWELL_HI = 3'd2,
        ST_DN       = 3'd3,
        ST_DWELL_LO = 3'd4,
        ST_HOMING   = 3'd5
    } state_e;

    localparam logic [1:0]  OP_STOP      = 2'b00;
    localparam logic [1:0]  OP_START     = 2'b01;
    localparam logic [1:0]  OP_HOME      = 2'b10;
    localparam logic [15:0] TICK_LAST    = 16'(TICK_DIV - 1);
    localparam logic [15:0] FRAME_LAST   = 16'(FRAME_TICKS - 1);
    localparam logic [7:0]  POS_MIN_C    = 8'(POS_MIN);
    localparam logic [7:0]  POS_MAX_C    = 8'(POS_MAX);
    localparam logic [7:0]  STEP_C       = 8'(STEP);
    // Saturation thresholds: compared before the add/sub so pos never wraps.
    localparam logic [7:0]  POS_HI_LIM   = 8'(POS_MAX - STEP);
    localparam logic [7:0]  POS_LO_LIM   = 8'(POS_MIN + STEP);
    localparam logic [7:0]  DWELL_UNIT_C = 8'(DWELL_UNIT);

    logic [15:0] tick_cnt_q, tick_cnt_d;
    logic [15:0] frame_cnt_q, frame_cnt_d;
    state_e      state_q, state_d;
    state_e      st_cmd_s, st_ramp_s;
    logic [7:0]  pos_q, pos_d;
    logic [7:0]  dwell_q, dwell_d;
    logic [7:0]  dwell_load_s;
    logic        ready_q, ready_d;
    logic [1:0]  op_q, op_d;
    logic        pwm_q, pwm_d;
    logic        busy_q, busy_d;
    logic        tick_s, frame_start_s, xfer_s;

    // Tick divider and frame counter; frame_start marks the last clk of a frame.
    always_comb begin
        tick_s        = (tick_cnt_q == TICK_LAST);
        frame_start_s = tick_s && (frame_cnt_q == FRAME_LAST);
        if (tick_s) begin
            tick_cnt_d = 16'd0;
        end else begin
            tick_cnt_d = tick_cnt_q + 16'd1;
        end
        if (!tick_s) begin
            frame_cnt_d = frame_cnt_q;
        end else if (frame_cnt_q == FRAME_LAST) begin
            frame_cnt_d = 16'd0;
        end else begin
            frame_cnt_d = frame_cnt_q + 16'd1;
        end
    end

    // Command slot: cmd_ready low means a command is pending for the next frame boundary.
    always_comb begin
        xfer_s  = cmd.cmd_valid && ready_q;
        ready_d = ready_q;
        op_d    = op_q;
        if (xfer_s) begin
            ready_d = 1'b0;
            op_d    = cmd.cmd_op;
        end else if (frame_start_s && !ready_q) begin
            ready_d = 1'b1;
        end else begin
            ready_d = ready_q;
        end
    end

    // Next-state logic: pending command first, then dwell countdown, then position ramp.
    always_comb begin
        st_cmd_s     = state_q;
        st_ramp_s    = state_q;
        state_d      = state_q;
        pos_d        = pos_q;
        dwell_d      = dwell_q;
        dwell_load_s = 8'({5'd0, cmd.speed} * DWELL_UNIT_C);
        if (frame_start_s) begin
            if (!ready_q) begin
                case (op_q)
                    OP_STOP:  st_cmd_s = ST_IDLE;
                    OP_START: st_cmd_s = (state_q == ST_IDLE) ? ST_UP : state_q;
                    OP_HOME:  st_cmd_s = ST_HOMING;
                    default:  st_cmd_s = state_q;
                endcase
            end else begin
                st_cmd_s = state_q;
            end
            // The frame on which the dwell expires already ramps away from the endpoint.
            case (st_cmd_s)
                ST_DWELL_HI: begin
                    if (dwell_q <= 8'd1) begin
                        st_ramp_s = ST_DN;
                    end else begin
                        st_ramp_s = ST_DWELL_HI;
                        dwell_d   = dwell_q - 8'd1;
                    end
                end
                ST_DWELL_LO: begin
                    if (dwell_q <= 8'd1) begin
                        st_ramp_s = ST_UP;
                    end else begin
                        st_ramp_s = ST_DWELL_LO;
                        dwell_d   = dwell_q - 8'd1;
                    end
                end
                default: st_ramp_s = st_cmd_s;
            endcase
            state_d = st_ramp_s;
            case (st_ramp_s)
                ST_UP: begin
                    if (pos_q >= POS_HI_LIM) begin
                        pos_d = POS_MAX_C;
                        if (cmd.speed == 3'd0) begin
                            state_d = ST_DN;
                        end else begin
                            state_d = ST_DWELL_HI;
                            dwell_d = dwell_load_s;
                        end
                    end else begin
                        pos_d = pos_q + STEP_C;
                    end
                end
                ST_DN: begin
                    if (pos_q <= POS_LO_LIM) begin
                        pos_d = POS_MIN_C;
                        if (cmd.speed == 3'd0) begin
                            state_d = ST_UP;
                        end else begin
                            state_d = ST_DWELL_LO;
                            dwell_d = dwell_load_s;
                        end
                    end else begin
                        pos_d = pos_q - STEP_C;
                    end
                end
                ST_HOMING: begin
                    if (pos_q <= POS_LO_LIM) begin
                        pos_d   = POS_MIN_C;
                        state_d = ST_IDLE;
                    end else begin
                        pos_d = pos_q - STEP_C;
                    end
                end
                default: pos_d = pos_q;
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // Output decode; pos only moves at the frame boundary so the pulse cannot glitch.
    always_comb begin
        pwm_d  = (frame_cnt_q < {8'd0, pos_q});
        busy_d = (state_d != ST_IDLE);
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt_q  <= 16'd0;
            frame_cnt_q <= 16'd0;
            state_q     <= ST_IDLE;
            pos_q       <= POS_MIN_C;
            dwell_q     <= 8'd0;
            ready_q     <= 1'b1;
            op_q        <= 2'b00;
            pwm_q       <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            tick_cnt_q  <= tick_cnt_d;
            frame_cnt_q <= frame_cnt_d;
            state_q     <= state_d;
            pos_q       <= pos_d;
            dwell_q     <= dwell_d;
            ready_q     <= ready_d;
            op_q        <= op_d;
            pwm_q       <= pwm_d;
            busy_q      <= busy_d;
        end
    end

    assign pwm_out       = pwm_q;
    assign pos           = pos_q;
    assign busy          = busy_q;
    assign cmd.cmd_ready = ready_q;

`ifdef SERVO_ENDPOINT_IRQ_EN
    logic irq_q, irq_d;

    // Only a ramp moves pos, so any move that lands on an endpoint is an arrival.
    always_comb begin
        irq_d = frame_start_s && (pos_d != pos_q) &&
                ((pos_d == POS_MAX_C) || (pos_d == POS_MIN_C));
    end

    // Endpoint pulse register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= irq_d;
        end
    end

    assign end_irq = irq_q;
`endif

endmodule
